// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: entry layout and intake FSM encoding.
package uart_pkg;

   localparam int ENTRY_W  = 12;
   localparam int DATA_LSB = 0;
   localparam int PERR     = 9;
   localparam int OVF      = 10;
   localparam int BRK      = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      WAIT = 2'd2
   } rxState_t;

   function automatic logic [ENTRY_W-1:0] packEntry(input logic brk, input logic ovf,
                                                    input logic perr, input logic [8:0] data);
      logic [ENTRY_W-1:0] e;
      e            = '0;
      e[BRK]       = brk;
      e[OVF]       = ovf;
      e[PERR]      = perr;
      e[DATA_LSB+:9] = data;
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; head entry, count and flags are all registered.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         headData,
   output logic                     notEmpty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    rdPtrNext;
   logic [PW:0]      countNext;
   logic [WIDTH-1:0] headNext;
   logic             doPush;
   logic             doPop;

   // Next-state of pointers, level and head entry
   always_comb begin
      doPush    = push && !full;
      doPop     = pop && notEmpty;
      rdPtrNext = doPop ? rdPtr + 1'b1 : rdPtr;
      if (doPush && !doPop) begin
         countNext = count + 1'b1;
      end else if (doPop && !doPush) begin
         countNext = count - 1'b1;
      end else begin
         countNext = count;
      end
      // A push landing exactly on the next head slot bypasses the memory read
      if (countNext == '0) begin
         headNext = '0;
      end else if (doPush && (wrPtr == rdPtrNext)) begin
         headNext = pushData;
      end else begin
         headNext = mem[rdPtrNext];
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointers, level and registered show-ahead outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         full     <= 1'b0;
         notEmpty <= 1'b0;
         headData <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         rdPtr    <= rdPtrNext;
         count    <= countNext;
         full     <= (countNext == FULL_LVL);
         notEmpty <= (countNext != '0);
         headData <= headNext;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive-side intake FSM, overrun tracking and host FIFO.
// Optional level interrupt output enabled by UART_RX_FIFO_THRESHOLD_IRQ_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int THRESHOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [8:0]               rxData,
   input  logic                     rxDataReceived,
   input  logic                     rxParityError,
   input  logic                     rxOverflow,
   input  logic                     rxBreak,
   output logic                     rxAck,
   output logic [ENTRY_W-1:0]       dataOut,
   output logic                     dataValid,
   input  logic                     read,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overrun,
   input  logic                     clearOverrun
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
   ,
   output logic                     levelIrq
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   rxState_t           state;
   logic               push;
   logic [ENTRY_W-1:0] entry;

   // Write strobe and packed entry for the FIFO
   always_comb begin
      push  = (state == IDLE) && rxDataReceived && !full;
      entry = packEntry(rxBreak, rxOverflow, rxParityError, rxData);
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pushData (entry),
      .pop      (read),
      .headData (dataOut),
      .notEmpty (dataValid),
      .full     (full),
      .count    (count)
   );

   // Intake FSM with registered acknowledge, plus sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rxAck   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rxAck <= push;
               state <= push ? ACK : IDLE;
            end
            ACK: begin
               rxAck <= 1'b0;
               state <= WAIT;
            end
            // Hold until the receiver drops its valid so one character is written once
            WAIT: begin
               rxAck <= 1'b0;
               state <= rxDataReceived ? WAIT : IDLE;
            end
            default: begin
               rxAck <= 1'b0;
               state <= IDLE;
            end
         endcase
         if ((state == IDLE) && rxDataReceived && full) begin
            overrun <= 1'b1;
         end else if (clearOverrun) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
   localparam logic [CW-1:0] THR_LVL = CW'(THRESHOLD);

   // Level interrupt follows registered count and overrun by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         levelIrq <= 1'b0;
      end else begin
         levelIrq <= (count >= THR_LVL) || overrun;
      end
   end
`else
   logic unusedThreshold;
   assign unusedThreshold = (THRESHOLD > CW);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries, a monitor checks each pop.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  rxData;
   logic        rxDataReceived;
   logic        rxParityError;
   logic        rxOverflow;
   logic        rxBreak;
   logic        rxAck;
   logic [11:0] dataOut;
   logic        dataValid;
   logic        read;
   logic [4:0]  count;
   logic        full;
   logic        overrun;
   logic        clearOverrun;
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
   logic        levelIrq;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [11:0] expQ[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16), .THRESHOLD(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .rxData         (rxData),
      .rxDataReceived (rxDataReceived),
      .rxParityError  (rxParityError),
      .rxOverflow     (rxOverflow),
      .rxBreak        (rxBreak),
      .rxAck          (rxAck),
      .dataOut        (dataOut),
      .dataValid      (dataValid),
      .read           (read),
      .count          (count),
      .full           (full),
      .overrun        (overrun),
      .clearOverrun   (clearOverrun)
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
      ,
      .levelIrq       (levelIrq)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startChar(input logic [8:0] d, input logic perr, input logic ovf, input logic brk);
      rxData         = d;
      rxParityError  = perr;
      rxOverflow     = ovf;
      rxBreak        = brk;
      rxDataReceived = 1'b1;
      expQ.push_back({brk, ovf, perr, d});
   endtask

   task automatic finishChar(input string name);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         if (rxAck === 1'b1) seen = 1'b1;
         else n++;
      end
      check({name, "-ack"}, seen, 1);
      tick();
      rxDataReceived = 1'b0;
      @(negedge clk);
      check({name, "-ackpulse"}, rxAck, 0);
   endtask

   task automatic sendChar(input logic [8:0] d, input logic perr, input logic ovf,
                           input logic brk, input string name);
      tick();
      startChar(d, perr, ovf, brk);
      finishChar(name);
   endtask

   task automatic popN(input int n);
      tick();
      read = 1'b1;
      repeat (n) tick();
      read = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill16(input logic [8:0] base);
      logic [8:0] d;
      for (int i = 0; i < 16; i++) begin
         d = base + 9'(i);
         sendChar(d, 1'b0, 1'b0, 1'b0, "fill");
      end
   endtask

   // Monitor: every accepted pop is compared with the oldest expected entry
   always @(negedge clk) begin
      if (rst === 1'b0 && read === 1'b1 && dataValid === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop-unexpected: got %0h expected none", dataOut);
         end else begin
            check("pop-data", dataOut, expQ.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global-timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0] d;
      int acks;
      rst = 1'b1; rxData = 9'h000; rxDataReceived = 1'b0; rxParityError = 1'b0;
      rxOverflow = 1'b0; rxBreak = 1'b0; read = 1'b0; clearOverrun = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst-ack", rxAck, 0);
      check("rst-valid", dataValid, 0);
      check("rst-count", count, 0);
      check("rst-full", full, 0);
      check("rst-overrun", overrun, 0);
      check("rst-data", dataOut, 0);

      // 1: reset while the FSM sits in WAIT
      tick();
      rxData = 9'h033; rxDataReceived = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("wait-ack", rxAck, 1);
      tick();
      tick();
      rst = 1'b1; rxDataReceived = 1'b0;
      tick();
      @(negedge clk);
      check("wrst-ack", rxAck, 0);
      check("wrst-count", count, 0);
      check("wrst-valid", dataValid, 0);
      check("wrst-overrun", overrun, 0);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      check("wrst-idle", count, 0);

      // 2: single character
      sendChar(9'h060, 1'b0, 1'b0, 1'b0, "single");
      check("single-data", dataOut, 12'h060);
      check("single-valid", dataValid, 1);
      check("single-count", count, 1);
      popN(1);
      check("single-empty", dataValid, 0);
      check("single-count0", count, 0);

      // 3: status flags packed above the data
      sendChar(9'h0A5, 1'b1, 1'b0, 1'b1, "flags");
      check("flags-data", dataOut, 12'hAA5);
      popN(1);

      // 4: fill, overrun on 17th, wrap-around
      fill16(9'h000);
      check("fill-count", count, 16);
      check("fill-full", full, 1);
      tick();
      startChar(9'h010, 1'b0, 1'b0, 1'b0);
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (rxAck === 1'b1) acks++;
      end
      check("full-noack", acks, 0);
      check("full-overrun", overrun, 1);
      tick();
      read = 1'b1;
      tick();
      read = 1'b0;
      finishChar("c17");
      check("c17-count", count, 16);
      popN(16);
      check("wrap-count", count, 0);

      // 5: simultaneous push/pop, empty read, set-wins overrun
      tick();
      clearOverrun = 1'b1;
      tick();
      clearOverrun = 1'b0;
      @(negedge clk);
      check("ovr-clear", overrun, 0);
      for (int i = 0; i < 5; i++) begin
         d = 9'h100 + 9'(i);
         sendChar(d, 1'b0, 1'b0, 1'b0, "five");
      end
      check("five-count", count, 5);
      tick();
      startChar(9'h105, 1'b0, 1'b0, 1'b0);
      read = 1'b1;
      tick();
      read = 1'b0;
      finishChar("simul");
      check("simul-count", count, 5);
      popN(5);
      check("simul-empty", count, 0);
      popN(1);
      check("emptyrd-count", count, 0);
      check("emptyrd-valid", dataValid, 0);

      fill16(9'h0C0);
      tick();
      startChar(9'h0D0, 1'b0, 1'b0, 1'b0);
      clearOverrun = 1'b1;
      tick();
      clearOverrun = 1'b0;
      @(negedge clk);
      check("setwins-overrun", overrun, 1);
      tick();
      read = 1'b1;
      tick();
      read = 1'b0;
      finishChar("c17b");
      popN(16);
      tick();
      clearOverrun = 1'b1;
      tick();
      clearOverrun = 1'b0;
      @(negedge clk);
      check("ovr-clear2", overrun, 0);

`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
      // 6: threshold interrupt
      for (int i = 0; i < 7; i++) begin
         d = 9'h020 + 9'(i);
         sendChar(d, 1'b0, 1'b0, 1'b0, "irq");
      end
      tick();
      @(negedge clk);
      check("irq-below", levelIrq, 0);
      sendChar(9'h027, 1'b0, 1'b0, 1'b0, "irq8");
      check("irq-at", levelIrq, 1);
      popN(1);
      tick();
      @(negedge clk);
      check("irq-drop", levelIrq, 0);
      popN(7);
`endif

      check("queue-drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
